// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle for the multi-port register file.
//   rd_en/rd_addr      -> per-port read enables and packed read addresses
//   rd_data/rd_busy    <- registered read data and busy flag per read port
//   wr_en/wr_addr/wr_data -> per-port write enables, addresses and data
//   iss_en/iss_addr    -> mark a register as awaiting writeback
//   busy_vec           <- current scoreboard, one bit per register
// master = issue/execute side, slave = register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [DEPTH-1:0]         busy_vec;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with registered reads,
// same-cycle write-to-read forwarding, highest-index write-port priority,
// optional hardwired zero register and a per-register busy scoreboard.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (clears registers, reads, scoreboard)
//   bus  - regfile_mp_if slave: read/write/issue ports and scoreboard output
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic [DATA_W-1:0] w_regs_next [DEPTH];
    logic [DEPTH-1:0]  w_written;
    logic [DEPTH-1:0]  w_issued;
    logic [DEPTH-1:0]  w_busy_next;

    // Post-write register state; reads sample this so a same-cycle write is
    // forwarded. Ports are applied in ascending order so the highest-index
    // enabled port overwrites lower ones on an address collision.
    always_comb begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
            w_regs_next[r] = r_regs[r];
        end
        w_written = '0;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en[p]) begin
                w_regs_next[bus.wr_addr[p*ADDR_W +: ADDR_W]] = bus.wr_data[p*DATA_W +: DATA_W];
                w_written[bus.wr_addr[p*ADDR_W +: ADDR_W]]   = 1'b1;
            end
        end
        w_issued = '0;
        if (bus.iss_en) begin
            w_issued[bus.iss_addr] = 1'b1;
        end
        // A new issue dominates a completing writeback to the same register.
        w_busy_next = (r_busy & ~w_written) | w_issued;
        if (ZERO_REG != 0) begin
            w_regs_next[0] = '0;
            w_busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                r_regs[r] <= w_regs_next[r];
            end
            r_busy <= w_busy_next;
        end
    end

    assign bus.busy_vec = r_busy;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_rd_addr;
        logic [DATA_W-1:0] r_rd_data;
        logic              r_rd_busy;

        assign w_rd_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data <= '0;
                r_rd_busy <= 1'b0;
            end else if (bus.rd_en[i]) begin
                r_rd_data <= w_regs_next[w_rd_addr];
                r_rd_busy <= w_busy_next[w_rd_addr];
            end
        end

        assign bus.rd_data[i*DATA_W +: DATA_W] = r_rd_data;
        assign bus.rd_busy[i]                  = r_rd_busy;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the RISC-V core; next generation of the 2-read/1-write integer register file.
- Configurable width, depth, read-port count and write-port count, with registered reads and same-cycle write-to-read forwarding.
- Adds per-port read enables, deterministic write-port priority, an optional hardwired zero register and a per-register busy scoreboard used by issue logic to detect pending writebacks.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (power of two, >= 2)
- ADDR_W, $clog2(DEPTH), register address width
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..3); port 0 = ALU writeback, port 1 = memory writeback
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and issues

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- rd_en  input  NUM_RD  per-port read enable
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i in bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  registered read data; port i in bits [i*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  registered busy flag of the register read on port i
- wr_en  input  NUM_WR  per-port write enable
- wr_addr  input  NUM_WR*ADDR_W  write addresses, packed as rd_addr
- wr_data  input  NUM_WR*DATA_W  write data, packed as rd_data
- iss_en  input  1  mark iss_addr busy (destination of newly issued instruction)
- iss_addr  input  ADDR_W  register to mark busy
- busy_vec  output  DEPTH  current scoreboard, bit r = register r awaiting writeback

Behaviour:
- Reset (rst=1 at posedge): all registers, rd_data, rd_busy and busy_vec cleared to 0. Reset overrides writes, issues and reads in the same cycle. Reset applied mid-operation discards pending writes and busy bits.
- Write resolution per cycle: candidate ports are those with wr_en=1. If several target the same address, the highest-index port wins (memory writeback beats ALU). Writes to distinct addresses all commit. Commit happens at the posedge.
- ZERO_REG=1: writes to address 0 are dropped. Reads of address 0 return 0 and rd_busy=0. busy_vec[0] is always 0.
- Read, latency 1: when rd_en[i]=1 at a posedge, rd_data[i] takes the value of register rd_addr[i] after this cycle's writes are applied. A same-cycle write to that address is therefore forwarded, using the winning port's data.
- When rd_en[i]=0, rd_data[i] and rd_busy[i] hold their previous values.
- Read ports are independent; any ports may read the same address.
- Scoreboard next state: busy[r] = (busy[r] & ~written[r]) | issued[r].
  - written[r] = any wr_en targets r.
  - issued[r] = iss_en & iss_addr==r.
  - Issue and write to the same register in the same cycle leaves busy set (the new issue dominates).
  - Writing a non-busy register is legal and leaves it clear.
- rd_busy[i] on an enabled read is busy_next[rd_addr[i]]. It is consistent with the forwarded data: a register written this cycle and not re-issued reads as not busy.
- All outputs come directly from flops; no combinational path from inputs to outputs.
- Scaling: the implementation uses generate loops over NUM_RD/NUM_WR. No logic depends on the defaults.

Test Plan:
- Reset: preload r5=0x1234 then rst=1 for 1 cycle with wr_en[0]=1, addr 5, data 0xFFFF -> next read of r5 returns 0x00000000; busy_vec=0.
- Forwarding: in one cycle wr_en[0]=1 to r7=0xDEADBEEF, rd_en[0]=1 rd_addr[0]=7 -> rd_data[0]=0xDEADBEEF next cycle; rd_data[1] reading r8 is unaffected.
- Write collision: wr_en=2'b11 both addr 3, data0=0x11, data1=0x22 -> r3=0x22. Same-cycle forwarded read also returns 0x22.
- Zero register: write r0=0xAAAA and iss_en to r0 -> read r0 returns 0, rd_busy=0, busy_vec[0]=0. With ZERO_REG=0 the same sequence reads 0xAAAA.
- Scoreboard:
  - iss_en r9 -> busy_vec[9]=1 next cycle.
  - Read r9 -> rd_busy=1.
  - wr_en[1] r9=0x55 with simultaneous read -> rd_data=0x55, rd_busy=0, busy_vec[9]=0.
  - Issue and write r9 same cycle -> busy_vec[9] stays 1.
- Hold and params: rd_en=0 while r2 is rewritten -> rd_data holds the old value. Rerun forwarding and collision with NUM_RD=4, NUM_WR=3, DATA_W=64, DEPTH=64 -> port 2 wins a three-way collision.
